// File: rtl/am_seq_pkg.sv
// Shared definitions for the addressing-mode sequencer: opcodes, instruction
// field positions, FSM state encoding and opcode classification predicates.
package am_seq_pkg;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b1011;
  localparam logic [3:0] OP_MVI  = 4'b1100;
  localparam logic [3:0] OP_LDA  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int OP1_HI = 11;
  localparam int OP1_LO = 9;
  localparam int OP2_HI = 8;
  localparam int OP2_LO = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH2,
    S_RDREG,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_e;

  // Opcodes whose operand is the second instruction word.
  function automatic logic needs_imm(input logic [3:0] opc);
    return (opc == OP_MVI) || (opc == OP_LDA);
  endfunction

  function automatic logic needs_rdreg(input logic [3:0] opc);
    return opc == OP_MOV;
  endfunction

endpackage

// File: rtl/am_seq_decode.sv
// Combinational opcode classifier for the addressing-mode sequencer.
module am_seq_decode
  import am_seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_mov_o,
  output logic       is_imm_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  assign is_mov_o     = needs_rdreg(opcode_i);
  assign is_imm_o     = needs_imm(opcode_i);
  assign is_halt_o    = (opcode_i == OP_HALT);
  assign is_illegal_o = !(is_mov_o || is_imm_o || is_halt_o);

endmodule

// File: rtl/am_sequencer.sv
// Multi-cycle MOV/MVI/LDA/HALT sequencer feeding the addressing-mode unit.
// Optional AM_SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt instead of acting as NOPs.
module am_sequencer
  import am_seq_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter int               DATA_W   = 16,
  parameter int               REG_AW   = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        am_opcode,
  output logic [DATA_W-1:0] am_op2_data,
  output logic [DATA_W-1:0] am_op1_regaddr,
  output logic [DATA_W-1:0] am_op2_regaddr,
  input  logic [DATA_W-1:0] am_outdata,
  input  logic [DATA_W-1:0] am_outregaddr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   instrReg_q;
  logic                imemReq_q, busy_q, halted_q, illegal_q, rfWe_q;
  logic [REG_AW-1:0]   wbAddr_q;
  logic [DATA_W-1:0]   wbData_q;
  logic [3:0]          amOpcode_q;
  logic [DATA_W-1:0]   amOp2Data_q, amOp1Reg_q, amOp2Reg_q;

  logic [3:0]          opcode;
  logic [REG_AW-1:0]   op1Field;
  logic                isMov, isImm, isHalt, isIllegal;
  logic                fetchDone;
  logic                unusedBits;

  assign opcode    = instrReg_q[OPC_HI:OPC_LO];
  assign op1Field  = instrReg_q[OP1_HI:OP1_LO];
  assign fetchDone = ((state_q == S_FETCH) || (state_q == S_FETCH2)) && imem_valid;
  assign unusedBits = ^{instrReg_q[OP2_LO-1:0], am_outregaddr[DATA_W-1:REG_AW]};

  am_seq_decode u_decode (
    .opcode_i     (opcode),
    .is_mov_o     (isMov),
    .is_imm_o     (isImm),
    .is_halt_o    (isHalt),
    .is_illegal_o (isIllegal)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (isMov)       state_d = S_RDREG;
        else if (isImm)  state_d = S_FETCH2;
        else if (isHalt) state_d = S_HALTED;
        else begin
`ifdef AM_SEQ_ILLEGAL_TRAP_EN
          state_d = S_HALTED;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_FETCH2: if (imem_valid) state_d = S_EXEC;
      S_RDREG:  state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instrReg_q  <= '0;
      imemReq_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      rfWe_q      <= 1'b0;
      wbAddr_q    <= '0;
      wbData_q    <= '0;
      amOpcode_q  <= OP_NONE;
      amOp2Data_q <= '0;
      amOp1Reg_q  <= '0;
      amOp2Reg_q  <= '0;
    end else begin
      state_q   <= state_d;
      imemReq_q <= (state_d == S_FETCH) || (state_d == S_FETCH2);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_HALTED);
      halted_q  <= (state_d == S_HALTED);
      rfWe_q    <= (state_d == S_WB);

      if (fetchDone) pc_q <= pc_q + ADDR_W'(1);
      if ((state_q == S_FETCH) && imem_valid) instrReg_q <= imem_rdata;
      if ((state_q == S_DECODE) && isIllegal) illegal_q <= 1'b1;

      // Operands are loaded on EXEC entry and held until WB completes.
      if (state_d == S_EXEC) begin
        amOpcode_q  <= opcode;
        amOp1Reg_q  <= {{(DATA_W-REG_AW){1'b0}}, op1Field};
        amOp2Data_q <= (state_q == S_RDREG)  ? rf_rdata   : '0;
        amOp2Reg_q  <= (state_q == S_FETCH2) ? imem_rdata : '0;
      end else if (state_d != S_WB) begin
        amOpcode_q  <= OP_NONE;
        amOp1Reg_q  <= '0;
        amOp2Data_q <= '0;
        amOp2Reg_q  <= '0;
      end

      if (state_q == S_EXEC) begin
        wbData_q <= am_outdata;
        wbAddr_q <= am_outregaddr[REG_AW-1:0];
      end
    end
  end

  assign imem_req       = imemReq_q;
  assign imem_addr      = pc_q;
  assign rf_raddr       = instrReg_q[OP2_HI:OP2_LO];
  assign rf_we          = rfWe_q;
  assign rf_waddr       = wbAddr_q;
  assign rf_wdata       = wbData_q;
  assign am_opcode      = amOpcode_q;
  assign am_op2_data    = amOp2Data_q;
  assign am_op1_regaddr = amOp1Reg_q;
  assign am_op2_regaddr = amOp2Reg_q;
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign illegal_op     = illegal_q;

endmodule
